melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Multi-voice, parametrised melody sequencer: fetches note records from an external byte-wide synchronous ROM and plays up to CHANNELS simultaneous square-wave voices for a shared duration per record. Adds end-of-melody marker, loop mode, pause/resume, rests and a note counter. Sits between the melody ROM and the audio output pins, alongside the display debug path.

## Interface
- CLOCK_HZ, 10_000_000, system clock frequency; must be an integer multiple of 1_000_000.
- ADDRESS_WIDTH, 12, ROM byte-address width.
- CHANNELS, 2, number of voices, 1..4.
- Clock  in  1  system clock; the only clock.
- Reset  in  1  reset, synchronous, active-high.
- Play_i  in  1  level; sampled in IDLE, starts the melody at address 0.
- Stop_i  in  1  abort, highest priority.
- Pause_i  in  1  level; holds playback while high.
- Loop_i  in  1  level; sampled at the end marker.
- Address_o  out  ADDRESS_WIDTH  ROM byte address.
- Data_i  in  8  ROM data, valid one cycle after Address_o.
- SoundWave_o  out  CHANNELS  square wave per voice.
- Busy_o  out  1  high whenever State != IDLE.
- Paused_o  out  1  high in PAUSED.
- Done_o  out  1  one-cycle pulse on end marker without loop.
- Duration_o  out  16  current record duration, ms (debug).
- NoteCount_o  out  16  records played since Play_i, wraps at 65535.

## Operation
- Record = RECORD_BYTES = 2 + 2*CHANNELS bytes, big-endian: Duration_ms, then HalfPeriod_us[0..CHANNELS-1].
- Duration 0 = end marker (half-periods not read; fetch stops after 2 bytes). HalfPeriod 0 = rest: voice held low.
- States: IDLE, FETCH, PLAY, PAUSED.
- IDLE: outputs low; on Play_i: Address_o <= 0, NoteCount_o <= 0, -> FETCH.
- FETCH: Address_o increments every cycle; byte k captured the cycle after its address. After last byte: -> PLAY, NoteCount_o += 1. If captured duration is 0: Loop_i ? (Address_o <= 0, stay FETCH) : (Done_o pulse, -> IDLE).
- PLAY: ms prescaler (CLOCK_HZ/1000) and per-voice us counters (CLOCK_HZ/1_000_000 prescaler) run from zero. Each non-rest voice toggles after HalfPeriod_us us. When ms count == Duration: -> FETCH at next record address.
- Pause_i high in PLAY -> PAUSED: all counters frozen, SoundWave_o held low; Pause_i low -> PLAY resumes from frozen counts, voices restart low.
- Stop_i in any state: -> IDLE next cycle, SoundWave_o, Duration_o cleared; Done_o not pulsed.
- Address wrap: Address_o rolls from 2^ADDRESS_WIDTH-1 to 0 mid-record; bytes continue in order.
- Play_i outside IDLE ignored. Stop_i and Pause_i together: Stop_i wins.

## Timing
- Reset: State IDLE, Address_o 0, SoundWave_o 0, Busy_o 0, Paused_o 0, Done_o 0, Duration_o 0, NoteCount_o 0.
- Play_i sampled cycle t: Busy_o high t+1; first record fetch occupies RECORD_BYTES+1 cycles; PLAY entered cycle t+RECORD_BYTES+2.
- Note length in PLAY: exactly Duration*CLOCK_HZ/1000 cycles (excluding paused cycles); inter-note gap = RECORD_BYTES+1 cycles, voices low.
- Voice first edge (low->high) HalfPeriod*CLOCK_HZ/1_000_000 cycles after PLAY entry.
- End marker: Done_o high the cycle State returns to IDLE.

## Structure
- Package melody_pkg: state encoding, RECORD_BYTES function, tick-divider constants.
- Sub-module tone_channel: one voice (half-period compare, toggle, rest, freeze/clear); instantiated CHANNELS times via generate.
- ROM stays outside the block.

## Test plan
CLOCK_HZ=1_000_000, CHANNELS=2, ROM model one-cycle latency.
- Record {10 ms, 500 us, 250 us} then marker, Loop_i=0 -> voice0 10 periods of 1000 cycles, voice1 20 periods of 500 cycles; Done_o pulse once; NoteCount_o=2.
- Same ROM, Loop_i=1 -> record replays, Address_o returns to 0, Done_o never asserted.
- Record {5 ms, 0, 100} -> SoundWave_o[0] stays low, [1] toggles every 100 cycles for 5000 cycles.
- Pause_i high 2000 cycles mid-note -> Paused_o high, waves low, total note time 10000+2000 cycles.
- Stop_i mid-note and simultaneously with Pause_i -> IDLE next cycle, all outputs 0, no Done_o.
- Reset asserted in FETCH, ADDRESS_WIDTH=4 with record straddling 15->0 -> reset values next cycle; wrapped record bytes captured in order.

Source files
------------

// File: rtl/melody_pkg.sv
// melody_sequencer shared definitions
// state codes, record geometry and tick dividers
package melody_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  localparam int HZ_PER_KHZ = 1000;
  localparam int HZ_PER_MHZ = 1_000_000;

  typedef struct packed {
    logic clear;
    logic mute;
    logic run;
  } tone_ctrl_t;

  function automatic int record_bytes(input int ch);
    return 2 + 2 * ch;
  endfunction

  function automatic int ms_div(input int hz);
    return hz / HZ_PER_KHZ;
  endfunction

  function automatic int us_div(input int hz);
    return hz / HZ_PER_MHZ;
  endfunction

endpackage

// File: rtl/melody_sequencer_tone_channel.sv
// one square-wave voice
// toggles every i_half microsecond ticks; zero half-period is a rest
module tone_channel
  import melody_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  tone_ctrl_t  i_ctrl,
  input  logic        i_tick,
  input  logic [15:0] i_half,
  output logic        o_wave
);

  logic [15:0] r_count;
  logic        r_wave;
  logic        w_rest;
  logic        w_hit;

  assign w_rest = (i_half == 16'd0);
  assign w_hit  = ((r_count + 16'd1) == i_half);
  assign o_wave = r_wave;

  // half-period counter; mute keeps the count so a resume continues in phase
  always_ff @(posedge i_clk) begin
    if (i_rst || i_ctrl.clear) begin
      r_count <= 16'd0;
      r_wave  <= 1'b0;
    end else if (i_ctrl.mute) begin
      r_wave <= 1'b0;
    end else if (i_ctrl.run && i_tick && !w_rest) begin
      if (w_hit) begin
        r_count <= 16'd0;
        r_wave  <= ~r_wave;
      end else begin
        r_count <= r_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// multi-voice melody sequencer
// fetches records from a byte ROM and plays square-wave voices
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLOCK_HZ      = 10_000_000,
  parameter int ADDRESS_WIDTH = 12,
  parameter int CHANNELS      = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Play_i,
  input  logic                     Stop_i,
  input  logic                     Pause_i,
  input  logic                     Loop_i,
  output logic [ADDRESS_WIDTH-1:0] Address_o,
  input  logic [7:0]               Data_i,
  output logic [CHANNELS-1:0]      SoundWave_o,
  output logic                     Busy_o,
  output logic                     Paused_o,
  output logic                     Done_o,
  output logic [15:0]              Duration_o,
  output logic [15:0]              NoteCount_o
);

  localparam int RB     = record_bytes(CHANNELS);
  localparam int MS_DIV = ms_div(CLOCK_HZ);
  localparam int US_DIV = us_div(CLOCK_HZ);
  localparam int MS_W   = $clog2(MS_DIV + 1);
  localparam int US_W   = $clog2(US_DIV + 1);

  localparam logic [3:0]      CNT_LAST = 4'(RB);
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(MS_DIV - 1);
  localparam logic [US_W-1:0] US_LAST  = US_W'(US_DIV - 1);

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [3:0]               r_cnt;
  logic [7:0]               r_dur_hi;
  logic [15:0]              r_dur;
  logic [15:0]              r_ms;
  logic [MS_W-1:0]          r_ms_pre;
  logic [US_W-1:0]          r_us_pre;
  logic [15:0]              r_count;
  logic                     r_done;
  logic [15:0]              r_hp [CHANNELS];

  logic [15:0]         w_dur_new;
  logic                w_marker;
  logic                w_ms_tick;
  logic                w_note_end;
  logic                w_us_tick;
  logic                w_play;
  tone_ctrl_t          w_ctrl;
  logic [CHANNELS-1:0] w_wave;

  assign w_play     = (r_state == ST_PLAY);
  assign w_dur_new  = {r_dur_hi, Data_i};
  assign w_marker   = (w_dur_new == 16'd0);
  assign w_ms_tick  = w_play && (r_ms_pre == MS_LAST);
  assign w_note_end = w_ms_tick && ((r_ms + 16'd1) == r_dur);
  assign w_us_tick  = w_play && (r_us_pre == US_LAST);

  assign w_ctrl.clear = Stop_i
                     || (r_state == ST_IDLE)
                     || (r_state == ST_FETCH);
  assign w_ctrl.mute  = (r_state == ST_PAUSED);
  assign w_ctrl.run   = w_play;

  assign Address_o   = r_addr;
  assign SoundWave_o = w_wave & {CHANNELS{w_play}};
  assign Busy_o      = (r_state != ST_IDLE);
  assign Paused_o    = (r_state == ST_PAUSED);
  assign Done_o      = r_done;
  assign Duration_o  = r_dur;
  assign NoteCount_o = r_count;

  // control FSM: fetch bytes, time the note, handle pause/stop/loop
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_cnt    <= 4'd0;
      r_dur_hi <= 8'd0;
      r_dur    <= 16'd0;
      r_ms     <= 16'd0;
      r_ms_pre <= '0;
      r_us_pre <= '0;
      r_count  <= 16'd0;
      r_done   <= 1'b0;
    end else if (Stop_i) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_cnt    <= 4'd0;
      r_dur    <= 16'd0;
      r_ms     <= 16'd0;
      r_ms_pre <= '0;
      r_us_pre <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (Play_i) begin
            r_addr  <= '0;
            r_count <= 16'd0;
            r_cnt   <= 4'd0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt != CNT_LAST) begin
            r_addr <= r_addr + 1'b1;
          end
          if (r_cnt == 4'd1) begin
            r_dur_hi <= Data_i;
          end
          if (r_cnt == 4'd2) begin
            r_dur <= w_dur_new;
            if (w_marker) begin
              r_count <= r_count + 16'd1;
              r_addr  <= '0;
              if (Loop_i) begin
                r_cnt <= 4'd0;
              end else begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          if (r_cnt == CNT_LAST) begin
            r_state  <= ST_PLAY;
            r_count  <= r_count + 16'd1;
            r_ms     <= 16'd0;
            r_ms_pre <= '0;
            r_us_pre <= '0;
          end
        end
        ST_PLAY: begin
          if (w_ms_tick) begin
            r_ms_pre <= '0;
            r_ms     <= r_ms + 16'd1;
          end else begin
            r_ms_pre <= r_ms_pre + 1'b1;
          end
          if (w_us_tick) begin
            r_us_pre <= '0;
          end else begin
            r_us_pre <= r_us_pre + 1'b1;
          end
          if (w_note_end) begin
            r_state <= ST_FETCH;
            r_cnt   <= 4'd0;
          end else if (Pause_i) begin
            r_state <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!Pause_i) begin
            r_state <= ST_PLAY;
          end
        end
      endcase
    end
  end

  // half-period capture; byte 3+2c is the high byte of voice c
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_hp[c] <= 16'd0;
      end
    end else if (r_state == ST_FETCH) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_cnt == 4'(3 + 2 * c)) begin
          r_hp[c][15:8] <= Data_i;
        end
        if (r_cnt == 4'(4 + 2 * c)) begin
          r_hp[c][7:0] <= Data_i;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    tone_channel u_tone (
      .i_clk  (Clock),
      .i_rst  (Reset),
      .i_ctrl (w_ctrl),
      .i_tick (w_us_tick),
      .i_half (r_hp[g]),
      .o_wave (w_wave[g])
    );
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// melody_sequencer testbench
// event scoreboard on wave/done/busy/paused edges plus spot checks
module tb_melody_sequencer;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        rst, play, stop, pause, loop;
  logic [11:0] addr;
  logic [7:0]  data;
  logic [1:0]  wave;
  logic        busy, paused, done;
  logic [15:0] dur, ncnt;

  logic        rst4, play4;
  logic [3:0]  addr4;
  logic [7:0]  data4;
  logic [1:0]  wave4;
  logic        busy4, paused4, done4;
  logic [15:0] dur4, ncnt4;

  logic [7:0] rom  [0:4095];
  logic [7:0] rom4 [0:15];

  always @(posedge clk) begin
    data  <= rom[addr];
    data4 <= rom4[addr4];
  end

  melody_sequencer #(
    .CLOCK_HZ(1_000_000), .ADDRESS_WIDTH(12), .CHANNELS(2)
  ) dut (
    .Clock(clk), .Reset(rst), .Play_i(play), .Stop_i(stop),
    .Pause_i(pause), .Loop_i(loop), .Address_o(addr),
    .Data_i(data), .SoundWave_o(wave), .Busy_o(busy),
    .Paused_o(paused), .Done_o(done), .Duration_o(dur),
    .NoteCount_o(ncnt)
  );

  melody_sequencer #(
    .CLOCK_HZ(1_000_000), .ADDRESS_WIDTH(4), .CHANNELS(2)
  ) dut4 (
    .Clock(clk), .Reset(rst4), .Play_i(play4), .Stop_i(1'b0),
    .Pause_i(1'b0), .Loop_i(1'b0), .Address_o(addr4),
    .Data_i(data4), .SoundWave_o(wave4), .Busy_o(busy4),
    .Paused_o(paused4), .Done_o(done4), .Duration_o(dur4),
    .NoteCount_o(ncnt4)
  );

  // id: 0/1 wave, 2 done, 3 busy, 4 paused, 5/6 wave4, 7 done4
  ev_t q [8][$];
  logic [7:0] obs, prev;
  logic mon_en = 1'b0;

  assign obs = {done4, wave4[1], wave4[0], paused, busy, done,
                wave[1], wave[0]};

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 8; i++) begin
        if (obs[i] !== prev[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            failures++;
            $display("FAIL ev%0d unexpected edge cyc=%0d val=%b",
                     i, cyc, obs[i]);
          end else begin
            ev_t e;
            e = q[i].pop_front();
            if (e.cyc != cyc || e.val !== obs[i]) begin
              failures++;
              $display("FAIL ev%0d edge got cyc=%0d val=%b want cyc=%0d val=%b",
                       i, cyc, obs[i], e.cyc, e.val);
            end
          end
        end
      end
      prev = obs;
    end
  end

  function automatic void push(input int id, input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q[id].push_back(e);
  endfunction

  // edges of a voice playing n visible cycles from PLAY entry st
  function automatic void push_tone(input int id, input int st,
                                    input int hp, input int n);
    logic last;
    last = 1'b0;
    if (hp > 0) begin
      for (int k = 1; hp * k <= n - 1; k++) begin
        last = logic'(k % 2);
        push(id, st + hp * k, last);
      end
      if (last) push(id, st + n, 1'b0);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rec(input int a, input int d, input int h0,
                         input int h1);
    logic [15:0] v;
    v = 16'(d);  rom[a]   = v[15:8]; rom[a+1] = v[7:0];
    v = 16'(h0); rom[a+2] = v[15:8]; rom[a+3] = v[7:0];
    v = 16'(h1); rom[a+4] = v[15:8]; rom[a+5] = v[7:0];
  endtask

  task automatic start_play(output int t0);
    play = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    play = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, p0, p1, p2, s, a, d, c;
    rst = 1'b1; play = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
    rst4 = 1'b1; play4 = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    for (int i = 0; i < 16; i++) rom4[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wave", 32'(wave), 0);
    chk("rst_flags", {29'd0, busy, paused, done}, 0);
    chk("rst_dur", 32'(dur), 0);
    chk("rst_ncnt", 32'(ncnt), 0);
    rst = 1'b0;
    rst4 = 1'b0;
    prev = obs;
    mon_en = 1'b1;
    wait_until(cyc + 3);

    // one note then end marker, no loop
    set_rec(0, 10, 500, 250);
    t0 = cyc; p0 = t0 + 8; d = p0 + 10003;
    push(3, t0 + 1, 1'b1);
    push_tone(0, p0, 500, 10000);
    push_tone(1, p0, 250, 10000);
    push(2, d, 1'b1); push(2, d + 1, 1'b0);
    push(3, d, 1'b0);
    start_play(t0);
    wait_until(p0);
    chk("t1_dur", 32'(dur), 10);
    wait_until(d + 4);
    chk("t1_ncnt", 32'(ncnt), 2);

    // loop mode, stopped mid-note of the second pass
    loop = 1'b1;
    t0 = cyc; p0 = t0 + 8; p1 = p0 + 10010; s = p1 + 3300;
    push(3, t0 + 1, 1'b1);
    push_tone(0, p0, 500, 10000);
    push_tone(1, p0, 250, 10000);
    push_tone(0, p1, 500, s + 1 - p1);
    push_tone(1, p1, 250, s + 1 - p1);
    push(3, s + 1, 1'b0);
    start_play(t0);
    wait_until(p0 + 10003);
    chk("t2_loop_addr", 32'(addr), 0);
    chk("t2_loop_busy", 32'(busy), 1);
    wait_until(s);
    chk("t2_ncnt", 32'(ncnt), 3);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    loop = 1'b0;
    chk("t2_stop_flags", {29'd0, busy, paused, done}, 0);
    chk("t2_stop_wave", 32'(wave), 0);
    chk("t2_stop_dur", 32'(dur), 0);
    chk("t2_stop_addr", 32'(addr), 0);
    wait_until(cyc + 5);

    // rest on voice 0
    set_rec(0, 5, 0, 100);
    t0 = cyc; p0 = t0 + 8; d = p0 + 5003;
    push(3, t0 + 1, 1'b1);
    push_tone(1, p0, 100, 5000);
    push(2, d, 1'b1); push(2, d + 1, 1'b0);
    push(3, d, 1'b0);
    start_play(t0);
    wait_until(d + 4);
    chk("t3_ncnt", 32'(ncnt), 2);

    // pause 2000 cycles mid-note
    set_rec(0, 10, 500, 250);
    t0 = cyc; p0 = t0 + 8; a = p0 + 1300; d = p0 + 12003;
    push(3, t0 + 1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      c = 500 * k;
      push(0, (c <= 1300) ? p0 + c : p0 + c + 2000, logic'(k % 2));
    end
    for (int k = 1; k <= 5; k++) push(1, p0 + 250 * k, logic'(k % 2));
    push(1, a + 1, 1'b0);
    for (int k = 6; k <= 39; k++)
      push(1, p0 + 2000 + 250 * k, logic'((k % 2) == 0));
    push(4, a + 1, 1'b1); push(4, a + 2001, 1'b0);
    push(2, d, 1'b1); push(2, d + 1, 1'b0);
    push(3, d, 1'b0);
    start_play(t0);
    wait_until(a);
    pause = 1'b1;
    wait_until(a + 5);
    chk("t4_paused", 32'(paused), 1);
    chk("t4_pause_wave", 32'(wave), 0);
    wait_until(a + 2000);
    pause = 1'b0;
    wait_until(d + 4);

    // stop and pause together
    t0 = cyc; p0 = t0 + 8; s = p0 + 200;
    push(3, t0 + 1, 1'b1);
    push(3, s + 1, 1'b0);
    start_play(t0);
    wait_until(s);
    stop = 1'b1;
    pause = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    pause = 1'b0;
    chk("t5_flags", {29'd0, busy, paused, done}, 0);
    chk("t5_wave_dur", {14'd0, wave, dur}, 0);
    wait_until(cyc + 5);

    // 4-bit address: third record wraps 15 -> 0, reset mid-fetch
    rom4[1] = 8'h03;
    rom4[7] = 8'h01;
    rom4[13] = 8'h01;
    rom4[15] = 8'h07;
    t0 = cyc; p0 = t0 + 8; p1 = p0 + 3007; p2 = p1 + 1007;
    push_tone(5, p2, 7, 1000);
    push_tone(6, p2, 3, 1000);
    play4 = 1'b1;
    @(posedge clk);
    #1;
    play4 = 1'b0;
    wait_until(p2);
    chk("t6_dur", 32'(dur4), 1);
    chk("t6_next_addr", 32'(addr4), 2);
    chk("t6_ncnt", 32'(ncnt4), 3);
    wait_until(p2 + 1001);
    chk("t6_busy_fetch", 32'(busy4), 1);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    chk("t6_rst_addr", 32'(addr4), 0);
    chk("t6_rst_flags", {29'd0, busy4, paused4, done4}, 0);
    chk("t6_rst_wave_dur", {14'd0, wave4, dur4}, 0);
    chk("t6_rst_ncnt", 32'(ncnt4), 0);
    wait_until(cyc + 10);

    for (int i = 0; i < 8; i++) begin
      while (q[i].size() > 0) begin
        ev_t e;
        e = q[i].pop_front();
        checks++;
        failures++;
        $display("FAIL ev%0d missing edge want cyc=%0d val=%b",
                 i, e.cyc, e.val);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
